// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//   Captures one 16-point complex FFT result presented in parallel and
//   streams it out one bin per beat. Output order is bit-reversed capture
//   index (BITREV=1) or natural (BITREV=0). Data passes bit-exact.
//
// Handshakes (both sides): a word moves on a rising edge where valid && ready
//   are both high. Valid never depends combinationally on ready of the same
//   interface, and outputs hold stable while valid is high and ready is low.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   din_r0..din_r15     : real parts of the parallel frame (DW each)
//   din_i0..din_i15     : imaginary parts of the parallel frame (DW each)
//   in_valid / in_ready : input frame handshake
//   dout_r / dout_i     : current serial sample
//   dout_idx            : beat number k (frequency bin), 0 when idle
//   dout_last           : high on beat k=15, 0 when idle
//   out_valid/out_ready : output beat handshake
//   frame_cnt           : completed frames, wraps modulo 256
//   stateDbg            : current FSM state (0=IDLE, 1=SEND) for observation
module fft_out_serializer #(
    parameter int DW     = 16,
    parameter int BITREV = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din_r0,  din_r1,  din_r2,  din_r3,
    input  logic [DW-1:0] din_r4,  din_r5,  din_r6,  din_r7,
    input  logic [DW-1:0] din_r8,  din_r9,  din_r10, din_r11,
    input  logic [DW-1:0] din_r12, din_r13, din_r14, din_r15,
    input  logic [DW-1:0] din_i0,  din_i1,  din_i2,  din_i3,
    input  logic [DW-1:0] din_i4,  din_i5,  din_i6,  din_i7,
    input  logic [DW-1:0] din_i8,  din_i9,  din_i10, din_i11,
    input  logic [DW-1:0] din_i12, din_i13, din_i14, din_i15,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic [3:0]    dout_idx,
    output logic          dout_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    frame_cnt,
    output logic          stateDbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stateT;

    stateT         state, stateNext;
    logic [3:0]    k, kNext;
    logic [7:0]    frameCnt, frameCntNext;
    logic          outValid, inReady, transfer, capture, lastBeat;
    logic [3:0]    rdIdx;

    logic [DW-1:0] dinR  [16];
    logic [DW-1:0] dinI  [16];
    logic [DW-1:0] bankR [16];
    logic [DW-1:0] bankI [16];

    assign dinR[0]  = din_r0;   assign dinI[0]  = din_i0;
    assign dinR[1]  = din_r1;   assign dinI[1]  = din_i1;
    assign dinR[2]  = din_r2;   assign dinI[2]  = din_i2;
    assign dinR[3]  = din_r3;   assign dinI[3]  = din_i3;
    assign dinR[4]  = din_r4;   assign dinI[4]  = din_i4;
    assign dinR[5]  = din_r5;   assign dinI[5]  = din_i5;
    assign dinR[6]  = din_r6;   assign dinI[6]  = din_i6;
    assign dinR[7]  = din_r7;   assign dinI[7]  = din_i7;
    assign dinR[8]  = din_r8;   assign dinI[8]  = din_i8;
    assign dinR[9]  = din_r9;   assign dinI[9]  = din_i9;
    assign dinR[10] = din_r10;  assign dinI[10] = din_i10;
    assign dinR[11] = din_r11;  assign dinI[11] = din_i11;
    assign dinR[12] = din_r12;  assign dinI[12] = din_i12;
    assign dinR[13] = din_r13;  assign dinI[13] = din_i13;
    assign dinR[14] = din_r14;  assign dinI[14] = din_i14;
    assign dinR[15] = din_r15;  assign dinI[15] = din_i15;

    // Next-state and handshake logic.
    always_comb begin
        stateNext    = state;
        kNext        = k;
        frameCntNext = frameCnt;

        // rst gates the outputs directly so nothing leaks while reset is held.
        outValid = !rst && (state == SEND);
        lastBeat = (k == 4'd15);
        transfer = outValid && out_ready;
        // Accepting on the final-beat transfer gives back-to-back frames.
        inReady  = !rst && ((state == IDLE) || (transfer && lastBeat));
        capture  = in_valid && inReady;

        if (transfer) begin
            if (lastBeat) begin
                frameCntNext = frameCnt + 8'd1;
                stateNext    = IDLE;
                kNext        = 4'd0;
            end else begin
                kNext = k + 4'd1;
            end
        end

        if (capture) begin
            stateNext = SEND;
            kNext     = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 4'd0;
            frameCnt <= 8'd0;
        end else begin
            state    <= stateNext;
            k        <= kNext;
            frameCnt <= frameCntNext;
        end
    end

    // Bank has no reset: its contents are only visible after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 16; i++) begin
                bankR[i] <= dinR[i];
                bankI[i] <= dinI[i];
            end
        end
    end

    assign rdIdx = (BITREV != 0) ? {k[0], k[1], k[2], k[3]} : k;

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign dout_r    = outValid ? bankR[rdIdx] : '0;
    assign dout_i    = outValid ? bankI[rdIdx] : '0;
    assign dout_idx  = outValid ? k : 4'd0;
    assign dout_last = outValid && lastBeat;
    assign frame_cnt = frameCnt;
    assign stateDbg  = state;

endmodule
